// File: rtl/mul_accum_if.sv
// Stream bundle for mul_accum: 8-bit product input and ACC_W-bit result output.
// The master side is the producer/consumer; the slave side is the accumulator.
interface mul_accum_if #(
  parameter int unsigned ACC_W = 10
) ();
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_sum, out_ovf, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_sum, out_ovf, out_valid
  );
endinterface

// File: rtl/mul_accum.sv
// Sums each group of LEN unsigned 8-bit products into one ACC_W-bit result.
// The result is held on a valid/ready port with a sticky wrap flag.
module mul_accum #(
  parameter int unsigned LEN   = 4,
  parameter int unsigned ACC_W = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  mul_accum_if.slave  bus
);
  localparam int unsigned CntW = $clog2(LEN);

  typedef enum logic [0:0] {StAcc, StDone} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic               out_ovf_q, out_ovf_d;
  logic               valid_q, valid_d;
  logic [ACC_W:0]     add;

  // One extra bit captures the carry out of the wrapped accumulator.
  assign add = {1'b0, acc_q} + (ACC_W + 1)'(bus.in_data);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    sum_d     = sum_q;
    out_ovf_d = out_ovf_q;
    valid_d   = valid_q;
    if (clr_i) begin
      state_d = StAcc;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StAcc: begin
          if (bus.in_valid) begin
            if (cnt_q == CntW'(LEN - 1)) begin
              sum_d     = add[ACC_W-1:0];
              out_ovf_d = ovf_q | add[ACC_W];
              valid_d   = 1'b1;
              acc_d     = '0;
              cnt_d     = '0;
              ovf_d     = 1'b0;
              state_d   = StDone;
            end else begin
              acc_d = add[ACC_W-1:0];
              cnt_d = cnt_q + CntW'(1);
              ovf_d = ovf_q | add[ACC_W];
            end
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            valid_d = 1'b0;
            state_d = StAcc;
          end
        end
        default: state_d = StAcc;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StAcc;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sum_q     <= '0;
      out_ovf_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      sum_q     <= sum_d;
      out_ovf_q <= out_ovf_d;
      valid_q   <= valid_d;
    end
  end

  // in_ready depends on state only, never on out_ready.
  assign bus.in_ready  = (state_q == StAcc);
  assign bus.out_sum   = sum_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_valid = valid_q;
endmodule

// File: doc/mul_accum.md
# mul_accum

Downstream consumer of the 4x4 adder-tree multiplier: accepts a stream of 8-bit products with a valid/ready handshake and sums each group of LEN consecutive products into one ACC_W-bit result (dot-product reduction). The result is presented on a valid/ready output port and held until taken. An overflow flag travels with each result. This is the reduction stage of the multiply-accumulate datapath.

## Interface
- LEN, 4: products per result; LEN >= 2.
- ACC_W, 10: accumulator and result width; ACC_W >= 8.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous, active-low.
- clr  in  1  synchronous abort of the current group and any held result.
- in_data  in  8  product from the multiplier, unsigned.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a product this cycle.
- out_sum  out  ACC_W  group sum, unsigned.
- out_ovf  out  1  group sum wrapped past 2^ACC_W.
- out_valid  out  1  out_sum/out_ovf are valid.
- out_ready  in  1  consumer takes the result this cycle.

## Operation
- States:
  - ACC: accepting products.
  - DONE: holding a result.
- Internal state:
  - acc: ACC_W bits.
  - cnt: clog2(LEN) bits, counts 0..LEN-1.
  - ovf_acc: sticky flag.
- Reset (rst low): state ACC, acc 0, cnt 0, ovf_acc 0, out_sum 0, out_ovf 0, out_valid 0.
- Handshakes:
  - in_ready = (state == ACC). It is a pure function of state, with no combinational path from out_ready.
  - Product accepted when in_valid && in_ready.
  - Result taken when out_valid && out_ready.
- Arithmetic: ACC_W+1-bit add of acc and zero-extended in_data. Carry-out sets ovf_acc. acc keeps the low ACC_W bits, i.e. the sum wraps modulo 2^ACC_W.
- Accept with cnt < LEN-1: acc <= sum, cnt <= cnt+1, ovf_acc |= carry.
- Accept with cnt == LEN-1 (the LEN-th product):
  - out_sum <= sum; out_ovf <= ovf_acc | carry; out_valid <= 1.
  - acc, cnt and ovf_acc <= 0.
  - state <= DONE.
- DONE: inputs ignored. On take: out_valid <= 0, state <= ACC. out_sum/out_ovf keep their last values.
- In ACC with in_valid low: nothing changes. Gaps between products are allowed.
- clr high (highest priority below reset): acc, cnt, ovf_acc <= 0; out_valid <= 0; state <= ACC. Any product or take in that cycle is discarded. out_sum/out_ovf are unchanged.

## Timing
- Latency: LEN-th product accepted at edge T -> out_valid high after T (visible in cycle T+1).
- Back-to-back throughput: LEN accept cycles plus at least one DONE cycle per group.
  - With out_ready held high, DONE lasts exactly 1 cycle.
  - First product of the next group is accepted the cycle after the take.
- out_valid, out_sum and out_ovf are stable while out_valid is high and out_ready is low.
- Reset mid-group or while in DONE: outputs and state return to reset values immediately (asynchronous). The partial group is lost.
- cnt wraps from LEN-1 to 0 only on group completion or clr; no other wrap exists.
- in_valid asserted during DONE is neither accepted nor counted. The producer holds it until in_ready.

## Test plan
- LEN=4, ACC_W=10: products 225,225,225,200 with in_valid held high.
  - Required: out_valid 1 cycle after the 4th accept, out_sum=875, out_ovf=0.
  - in_ready low exactly 1 cycle (out_ready=1).
- Overflow, LEN=4, ACC_W=9: four products of 225 (sum 900).
  - Required: out_sum=388, out_ovf=1.
  - The next group 1,2,3,4 -> out_sum=10, out_ovf=0 (flag cleared per group).
- Backpressure: after a result, hold out_ready=0 for 5 cycles while in_valid=1 with in_data=7.
  - Required: out_valid, out_sum and in_ready=0 held for all 5 cycles; no product counted.
  - After the take, the next group starts with the 7.
- Gapped input: products 10,(idle 3 cycles),20,(idle 1),30,40.
  - Required: out_sum=100, emitted 1 cycle after the 40 is accepted.
- clr: accept 50,60, then clr with in_valid=1, in_data=99, then 1,1,1,1.
  - Required: the 99 is discarded; out_sum=4.
  - A second check: clr while in DONE -> out_valid drops next cycle, out_sum unchanged.
- Async reset: drop rst between the 2nd and 3rd product.
  - Required: out_valid=0, out_sum=0, in_ready=1 without waiting for a clock edge.
  - After release, a full group 5,5,5,5 -> out_sum=20.
